stream_buffer: RTL and testbench
================================

STREAM_BUFFER -- requirements
Module: stream_buffer

Interface
REQ-001 Parameter DEPTH_LOG2, default 8: FIFO depth is 2**DEPTH_LOG2 bytes.
REQ-002 Parameter HIGH_WATER, default 192: at this fill level or above, rts_n is deasserted.
REQ-003 Parameter LOW_WATER, default 64: at this fill level or below, rts_n is reasserted; LOW_WATER < HIGH_WATER <= 2**DEPTH_LOG2.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 rx_data  input  8  byte from the serial receiver.
REQ-007 rx_available  input  1  one-cycle strobe; rx_data is valid in that cycle.
REQ-008 rts_n  output  1  flow control to the host; low = send allowed.
REQ-009 unicode  output  8  byte presented to terminal_stream.
REQ-010 unicode_available  output  1  one-cycle strobe; unicode is valid in that cycle.
REQ-011 ready_n  input  1  terminal_stream ready flag (registered in terminal_stream); low = ready.
REQ-012 fill_level  output  DEPTH_LOG2+1  current number of stored bytes.
REQ-013 overflow  output  1  sticky flag; a byte was dropped because the FIFO was full.

Function
REQ-014 Each rx_available strobe writes rx_data at wr_ptr and increments wr_ptr modulo depth, unless the FIFO is full.
REQ-015 A write while full drops the byte, leaves pointers and fill_level unchanged, and sets overflow.
REQ-016 overflow clears only on reset.
REQ-017 The output FSM has two states: IDLE and GAP.
REQ-018 IDLE: when fill_level != 0 and ready_n == 0, the FSM loads unicode <= mem[rd_ptr], sets unicode_available <= 1, increments rd_ptr and goes to GAP; otherwise it holds unicode_available at 0.
REQ-019 GAP: unicode_available <= 0 and the FSM goes to IDLE unconditionally.
REQ-020 GAP gives terminal_stream time to raise ready_n before the next decision.
REQ-021 Consequences of REQ-018/019: unicode_available is never high on two consecutive cycles; peak throughput is one byte per 2 cycles.
REQ-022 Latency: a byte strobed into an empty FIFO at edge N, with ready_n low, appears on unicode_available during the cycle after edge N+1.
REQ-023 A byte is consumed exactly once, at its strobe; no retry and no hold.
REQ-024 Simultaneous write and pop in one cycle: fill_level is unchanged.
REQ-025 Simultaneous write and pop when full: the write is accepted, because the pop frees a slot in the same cycle; overflow is not set.
REQ-026 Pop while empty is impossible, because REQ-018 gates the pop on fill_level != 0.
REQ-027 fill_level is registered and updated on the same edge as the pointers.
REQ-028 rts_n rises when fill_level, after the update, is >= HIGH_WATER.
REQ-029 rts_n falls when fill_level, after the update, is <= LOW_WATER.
REQ-030 Between the two thresholds, rts_n holds its previous value (hysteresis).
REQ-031 Pointer wrap-around is by natural DEPTH_LOG2-bit overflow.
REQ-032 Full is fill_level == 2**DEPTH_LOG2; empty is fill_level == 0.

Reset
REQ-033 On reset_n low, at any time including mid-pulse, the block immediately sets:
- FSM = IDLE
- unicode_available = 0
- unicode = 0
- wr_ptr = rd_ptr = 0
- fill_level = 0
- overflow = 0
- rts_n = 0
REQ-034 FIFO storage contents are not reset.
REQ-035 After reset_n rises, the first pop requires ready_n low; terminal_stream holds ready_n high during its own reset and clear-screen.

Structure
REQ-036 TRUE/FALSE/TRUE_n/FALSE_n come from the shared constant.v include; no local redefinition.
REQ-037 Storage is the sub-module stream_buffer_ram: synchronous-write, asynchronous-read, 8-bit wide, 2**DEPTH_LOG2 deep dual-port RAM.
REQ-038 Pointers, fill_level, FSM and flow control reside in stream_buffer.

Verification
REQ-039 Single byte: reset, hold ready_n low, strobe 0x41 -> unicode=0x41 with unicode_available high exactly one cycle, 2 cycles after the strobe; fill_level returns to 0.
REQ-040 Busy sink: hold ready_n high, strobe 0x41, 0x42, 0x43 -> no unicode_available and fill_level=3; then drop ready_n -> three pulses in order 0x41, 0x42, 0x43, each separated by one idle cycle.
REQ-041 Hysteresis: ready_n high, strobe 192 bytes -> rts_n rises on the edge that writes byte 192; release ready_n -> rts_n stays high until fill_level=64, then falls.
REQ-042 Overflow: ready_n high, strobe 257 bytes -> fill_level=256, overflow=1, first 256 bytes delivered intact after release; repeat with a pop and a write in the same cycle while full -> overflow stays 0.
REQ-043 Wrap and reset: stream 600 bytes (counting pattern) through with random ready_n -> output sequence is identical with no duplicates; assert reset_n low during a unicode_available pulse -> pulse ends immediately and fill_level=0.

Source files
------------

// File: rtl/stream_buffer_pkg.sv
// Shared constants and FSM encodings for the serial-to-terminal stream buffer.
// Active-high and active-low truth values live here so no block redefines them.
package stream_buffer_pkg;

  localparam logic TRUE    = 1'b1;
  localparam logic FALSE   = 1'b0;
  localparam logic TRUE_n  = 1'b0;
  localparam logic FALSE_n = 1'b1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_GAP  = 1'b1;

endpackage

// File: rtl/stream_buffer_ram.sv
// Byte-wide dual-port storage: synchronous write, asynchronous read.
// Contents are deliberately left unreset.
module stream_buffer_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [2**ADDR_W];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];

endmodule

// File: rtl/stream_buffer.sv
// Byte FIFO between the serial receiver and terminal_stream, with rts_n
// hysteresis flow control and a two-state paced output.
module stream_buffer
  import stream_buffer_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8,
  parameter int HIGH_WATER = 192,
  parameter int LOW_WATER  = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [7:0]          rx_data,
  input  logic                rx_available,
  output logic                rts_n,
  output logic [7:0]          unicode,
  output logic                unicode_available,
  input  logic                ready_n,
  output logic [DEPTH_LOG2:0] fill_level,
  output logic                overflow
);

  localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2+1)'(2**DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0] HW_LVL   = (DEPTH_LOG2+1)'(HIGH_WATER);
  localparam logic [DEPTH_LOG2:0] LW_LVL   = (DEPTH_LOG2+1)'(LOW_WATER);
  localparam logic [DEPTH_LOG2:0] ONE      = (DEPTH_LOG2+1)'(1);

  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [0:0]            state;
  logic [7:0]            rd_byte;
  logic                  full, empty, pop, wr_en, drop;
  logic [DEPTH_LOG2:0]   fill_next;

  stream_buffer_ram #(.ADDR_W(DEPTH_LOG2)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (rx_data),
    .raddr (rd_ptr),
    .rdata (rd_byte)
  );

  assign full  = (fill_level == FULL_LVL);
  assign empty = (fill_level == '0);
  assign pop   = (state == ST_IDLE) && !empty && (ready_n == TRUE_n);
  // A pop in the same cycle frees a slot, so a write while full still lands.
  assign wr_en = rx_available && (!full || pop);
  assign drop  = rx_available && full && !pop;

  always_comb begin
    fill_next = fill_level;
    if (wr_en && !pop)      fill_next = fill_level + ONE;
    else if (pop && !wr_en) fill_next = fill_level - ONE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= ST_IDLE;
      unicode_available <= FALSE;
      unicode           <= '0;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      fill_level        <= '0;
      overflow          <= FALSE;
      rts_n             <= TRUE_n;
    end else begin
      fill_level <= fill_next;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (drop) overflow <= TRUE;
      // Between the thresholds rts_n keeps its last value.
      if (fill_next >= HW_LVL)      rts_n <= FALSE_n;
      else if (fill_next <= LW_LVL) rts_n <= TRUE_n;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            unicode           <= rd_byte;
            unicode_available <= TRUE;
            rd_ptr            <= rd_ptr + 1'b1;
            state             <= ST_GAP;
          end else begin
            unicode_available <= FALSE;
          end
        end
        default: begin
          // One dead cycle lets terminal_stream raise ready_n before the next pop.
          unicode_available <= FALSE;
          state             <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stream_buffer.sv
// Scoreboard bench for stream_buffer: bytes queued on strobe, compared in
// order as unicode_available pulses are captured by the monitor.
module tb_stream_buffer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_available = 1'b0;
  logic       ready_n = 1'b1;
  logic       rts_n;
  logic [7:0] unicode;
  logic       unicode_available;
  logic [8:0] fill_level;
  logic       overflow;

  int checks = 0;
  int fails = 0;

  logic [7:0] exp_q[$];
  logic [7:0] obs_mem [2048];
  int         obs_cyc [2048];
  int         obs_wr = 0;
  int         obs_rd = 0;
  int         cyc = 0;
  int         b2b = 0;
  logic       prev_av = 1'b0;

  stream_buffer #(.DEPTH_LOG2(8), .HIGH_WATER(192), .LOW_WATER(64)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .rx_data           (rx_data),
    .rx_available      (rx_available),
    .rts_n             (rts_n),
    .unicode           (unicode),
    .unicode_available (unicode_available),
    .ready_n           (ready_n),
    .fill_level        (fill_level),
    .overflow          (overflow)
  );

  always #5 clk = ~clk;

  // Monitor: captures every output pulse mid-cycle, away from the active edge.
  always @(negedge clk) begin
    cyc     <= cyc + 1;
    prev_av <= unicode_available;
    if (unicode_available && prev_av) b2b <= b2b + 1;
    if (reset_n && unicode_available) begin
      obs_mem[obs_wr % 2048] <= unicode;
      obs_cyc[obs_wr % 2048] <= cyc;
      obs_wr <= obs_wr + 1;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] b, input bit push);
    rx_data = b;
    rx_available = 1'b1;
    if (push) exp_q.push_back(b);
    @(posedge clk); #1;
    rx_available = 1'b0;
  endtask

  task automatic wait_obs(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (obs_wr - obs_rd >= exp_q.size()) begin ok = 1'b1; break; end
      step(1);
    end
    if (obs_wr - obs_rd >= exp_q.size()) ok = 1'b1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(2);
    @(negedge clk) reset_n = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ready_n = 1'b1;
    step(3);
    checks++; if (unicode_available !== 1'b0) begin fails++; $display("FAIL reset_avail: got %b expected 0", unicode_available); end
    checks++; if (unicode !== 8'h00) begin fails++; $display("FAIL reset_unicode: got %h expected 00", unicode); end
    checks++; if (fill_level !== 9'd0) begin fails++; $display("FAIL reset_fill: got %0d expected 0", fill_level); end
    checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (rts_n !== 1'b0) begin fails++; $display("FAIL reset_rts_n: got %b expected 0", rts_n); end
    @(negedge clk) reset_n = 1'b1;
    step(1);
  endtask

  task automatic test_single();
    bit ok;
    ready_n = 1'b0;
    send(8'h41, 1'b1);
    checks++; if (unicode_available !== 1'b0 || fill_level !== 9'd1) begin fails++; $display("FAIL single_after_write: avail %b fill %0d expected 0/1", unicode_available, fill_level); end
    step(1);
    checks++; if (unicode_available !== 1'b1 || unicode !== 8'h41) begin fails++; $display("FAIL single_pulse: avail %b data %h expected 1/41", unicode_available, unicode); end
    step(1);
    checks++; if (unicode_available !== 1'b0 || fill_level !== 9'd0) begin fails++; $display("FAIL single_end: avail %b fill %0d expected 0/0", unicode_available, fill_level); end
    wait_obs(20, ok);
    checks++; if (!ok) begin fails++; $display("FAIL single_timeout: got %0d outputs expected %0d", obs_wr - obs_rd, exp_q.size()); end
    while (exp_q.size() != 0 && obs_rd != obs_wr) begin
      logic [7:0] e = exp_q.pop_front();
      checks++; if (obs_mem[obs_rd % 2048] !== e) begin fails++; $display("FAIL single_data: got %h expected %h", obs_mem[obs_rd % 2048], e); end
      obs_rd++;
    end
    exp_q.delete();
  endtask

  task automatic test_busy();
    bit ok;
    int base;
    ready_n = 1'b1;
    base = obs_wr;
    send(8'h41, 1'b1); send(8'h42, 1'b1); send(8'h43, 1'b1);
    step(4);
    checks++; if (fill_level !== 9'd3 || obs_wr != base) begin fails++; $display("FAIL busy_hold: fill %0d pulses %0d expected 3/0", fill_level, obs_wr - base); end
    ready_n = 1'b0;
    wait_obs(40, ok);
    checks++; if (!ok) begin fails++; $display("FAIL busy_timeout: got %0d outputs expected %0d", obs_wr - obs_rd, exp_q.size()); end
    if (ok) begin
      for (int k = 0; k < 2; k++) begin
        checks++; if (obs_cyc[(obs_rd+k+1) % 2048] - obs_cyc[(obs_rd+k) % 2048] != 2) begin fails++; $display("FAIL busy_spacing: got %0d cycles expected 2", obs_cyc[(obs_rd+k+1) % 2048] - obs_cyc[(obs_rd+k) % 2048]); end
      end
    end
    while (exp_q.size() != 0 && obs_rd != obs_wr) begin
      logic [7:0] e = exp_q.pop_front();
      checks++; if (obs_mem[obs_rd % 2048] !== e) begin fails++; $display("FAIL busy_data: got %h expected %h", obs_mem[obs_rd % 2048], e); end
      obs_rd++;
    end
    exp_q.delete();
    step(6);
    checks++; if (obs_wr != obs_rd || fill_level !== 9'd0) begin fails++; $display("FAIL busy_extra: extra pulses %0d fill %0d expected 0/0", obs_wr - obs_rd, fill_level); end
  endtask

  task automatic test_hysteresis();
    bit ok;
    int bad = 0;
    ready_n = 1'b1;
    for (int i = 0; i < 192; i++) begin
      send(8'(i + 8'h10), 1'b1);
      if (i == 190) begin checks++; if (rts_n !== 1'b0) begin fails++; $display("FAIL hyst_191: rts_n %b expected 0", rts_n); end end
      if (i == 191) begin checks++; if (rts_n !== 1'b1) begin fails++; $display("FAIL hyst_192: rts_n %b expected 1", rts_n); end end
    end
    ready_n = 1'b0;
    for (int c = 0; c < 600 && fill_level !== 9'd64; c++) begin
      step(1);
      if (fill_level > 9'd64 && rts_n !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin fails++; $display("FAIL hyst_hold: got %0d cycles low above 64 expected 0", bad); end
    checks++; if (fill_level !== 9'd64 || rts_n !== 1'b0) begin fails++; $display("FAIL hyst_low: fill %0d rts_n %b expected 64/0", fill_level, rts_n); end
    wait_obs(600, ok);
    checks++; if (!ok) begin fails++; $display("FAIL hyst_timeout: got %0d outputs expected %0d", obs_wr - obs_rd, exp_q.size()); end
    while (exp_q.size() != 0 && obs_rd != obs_wr) begin
      logic [7:0] e = exp_q.pop_front();
      checks++; if (obs_mem[obs_rd % 2048] !== e) begin fails++; $display("FAIL hyst_data: got %h expected %h", obs_mem[obs_rd % 2048], e); end
      obs_rd++;
    end
    exp_q.delete();
  endtask

  task automatic test_overflow();
    bit ok;
    ready_n = 1'b1;
    for (int i = 0; i < 257; i++) send(8'(i), i < 256);
    checks++; if (fill_level !== 9'd256 || overflow !== 1'b1) begin fails++; $display("FAIL ovf_full: fill %0d overflow %b expected 256/1", fill_level, overflow); end
    ready_n = 1'b0;
    wait_obs(1200, ok);
    checks++; if (!ok) begin fails++; $display("FAIL ovf_timeout: got %0d outputs expected %0d", obs_wr - obs_rd, exp_q.size()); end
    while (exp_q.size() != 0 && obs_rd != obs_wr) begin
      logic [7:0] e = exp_q.pop_front();
      checks++; if (obs_mem[obs_rd % 2048] !== e) begin fails++; $display("FAIL ovf_data: got %h expected %h", obs_mem[obs_rd % 2048], e); end
      obs_rd++;
    end
    exp_q.delete();
    step(4);
    checks++; if (overflow !== 1'b1 || obs_wr != obs_rd) begin fails++; $display("FAIL ovf_sticky: overflow %b extra %0d expected 1/0", overflow, obs_wr - obs_rd); end
    do_reset();
    checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_clear: overflow %b expected 0", overflow); end
  endtask

  task automatic test_full_simul();
    bit ok;
    ready_n = 1'b1;
    for (int i = 0; i < 256; i++) send(8'(255 - i), 1'b1);
    ready_n = 1'b0;
    send(8'hA5, 1'b1);
    ready_n = 1'b1;
    checks++; if (fill_level !== 9'd256 || overflow !== 1'b0) begin fails++; $display("FAIL simul_full: fill %0d overflow %b expected 256/0", fill_level, overflow); end
    ready_n = 1'b0;
    wait_obs(1200, ok);
    checks++; if (!ok) begin fails++; $display("FAIL simul_timeout: got %0d outputs expected %0d", obs_wr - obs_rd, exp_q.size()); end
    while (exp_q.size() != 0 && obs_rd != obs_wr) begin
      logic [7:0] e = exp_q.pop_front();
      checks++; if (obs_mem[obs_rd % 2048] !== e) begin fails++; $display("FAIL simul_data: got %h expected %h", obs_mem[obs_rd % 2048], e); end
      obs_rd++;
    end
    exp_q.delete();
  endtask

  task automatic test_wrap();
    bit ok;
    for (int i = 0; i < 600; i++) begin
      ready_n = ($urandom_range(0, 3) == 0);
      send(8'(i), 1'b1);
      ready_n = ($urandom_range(0, 3) == 0);
      step(2);
    end
    ready_n = 1'b0;
    wait_obs(1200, ok);
    checks++; if (!ok) begin fails++; $display("FAIL wrap_timeout: got %0d outputs expected %0d", obs_wr - obs_rd, exp_q.size()); end
    while (exp_q.size() != 0 && obs_rd != obs_wr) begin
      logic [7:0] e = exp_q.pop_front();
      checks++; if (obs_mem[obs_rd % 2048] !== e) begin fails++; $display("FAIL wrap_data: got %h expected %h", obs_mem[obs_rd % 2048], e); end
      obs_rd++;
    end
    exp_q.delete();
    step(4);
    checks++; if (overflow !== 1'b0 || b2b != 0 || obs_wr != obs_rd) begin fails++; $display("FAIL wrap_clean: overflow %b b2b %0d extra %0d expected 0/0/0", overflow, b2b, obs_wr - obs_rd); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int base;
    ready_n = 1'b0;
    send(8'h55, 1'b0);
    send(8'h66, 1'b0);
    checks++; if (unicode_available !== 1'b1 || fill_level !== 9'd1) begin fails++; $display("FAIL mid_pulse: avail %b fill %0d expected 1/1", unicode_available, fill_level); end
    base = obs_wr;
    reset_n = 1'b0;
    #1;
    checks++; if (unicode_available !== 1'b0 || fill_level !== 9'd0 || unicode !== 8'h00 || rts_n !== 1'b0) begin fails++; $display("FAIL mid_reset: avail %b fill %0d data %h rts_n %b expected 0/0/00/0", unicode_available, fill_level, unicode, rts_n); end
    @(negedge clk) reset_n = 1'b1;
    step(4);
    checks++; if (obs_wr != base || fill_level !== 9'd0) begin fails++; $display("FAIL mid_after: pulses %0d fill %0d expected 0/0", obs_wr - base, fill_level); end
    send(8'h7E, 1'b1);
    wait_obs(20, ok);
    checks++; if (!ok) begin fails++; $display("FAIL mid_timeout: got %0d outputs expected %0d", obs_wr - obs_rd, exp_q.size()); end
    while (exp_q.size() != 0 && obs_rd != obs_wr) begin
      logic [7:0] e = exp_q.pop_front();
      checks++; if (obs_mem[obs_rd % 2048] !== e) begin fails++; $display("FAIL mid_data: got %h expected %h", obs_mem[obs_rd % 2048], e); end
      obs_rd++;
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_busy();
    test_hysteresis();
    test_overflow();
    test_full_simul();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
